data_mem_responder: RTL and testbench

- Responder side of the pipeline's data-memory port: accepts load/store requests over a valid/ready request channel and returns a read data or write acknowledge over a valid/ready response channel.
- Inserts a programmable number of wait states.
- Checks word alignment.
- Maps one word address to an output register that drives the board display path.
- Sits between the MEM stage request logic and word-organised on-chip storage.

---
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Responder side of the data-memory port. Accepts one load/store at a time,
// waits LATENCY cycles, then presents a read-data or write-acknowledge
// response. One word address (IO_ADDR) is redirected to the io_out register
// that feeds the board display path instead of the storage array.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid=1 and ready=1. The sender holds its payload stable while
// valid=1 and the transfer has not happened; ready never depends
// combinationally on valid. req_ready and rsp_valid are registered.
module data_mem_responder #(
   parameter int                ADDR_W  = 10,
   parameter int                DATA_W  = 32,
   parameter int                LATENCY = 2,
   parameter logic [ADDR_W-1:0] IO_ADDR = 10'h3FC
) (
   input  logic              clk,
   input  logic              rst,        // asynchronous, active-low
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [DATA_W-1:0] io_out,
   output logic [1:0]        state_dbg   // current FSM state, for checkers
);

   localparam int WORDS = 2 ** (ADDR_W - 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state;
   logic [3:0]          wait_cnt;
   logic                we_q;
   logic                err_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   mem [WORDS];

   logic                accept;
   logic                req_misaligned;
   logic                req_is_io;
   logic                store_io;
   logic                store_mem;
   logic [ADDR_W-1:0]   rd_addr;
   logic                rd_we;
   logic                rd_err;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   rsp_rdata_next;

   assign state_dbg = state;

   // Request decode; stores commit on the accept edge itself so a load issued
   // right after a store always sees the new value.
   always_comb begin
      accept         = req_valid && req_ready;
      req_misaligned = (req_addr[1:0] != 2'b00);
      req_is_io      = (req_addr == IO_ADDR);
      store_io       = accept && req_we && !req_misaligned && req_is_io;
      // rst gating keeps the un-reset array from being written while the
      // FSM is held in reset with req_ready=1.
      store_mem      = accept && req_we && !req_misaligned && !req_is_io && rst;
   end

   // Load data source: the live request when LATENCY=0 (RESP is entered on the
   // accept edge), otherwise the latched request.
   always_comb begin
      rd_addr = (state == S_IDLE) ? req_addr : addr_q;
      rd_we   = (state == S_IDLE) ? req_we : we_q;
      rd_err  = (state == S_IDLE) ? req_misaligned : err_q;
      if (rd_addr == IO_ADDR) begin
         rd_word = io_out;
      end else begin
         rd_word = mem[rd_addr[ADDR_W-1:2]];
      end
      rsp_rdata_next = (rd_we || rd_err) ? '0 : rd_word;
   end

   // Word storage; not reset, IO_ADDR's aliased word is never written.
   always_ff @(posedge clk) begin
      if (store_mem) begin
         mem[req_addr[ADDR_W-1:2]] <= req_wdata;
      end
   end

   // Request/response FSM with registered handshake outputs and io_out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         io_out    <= '0;
         wait_cnt  <= 4'd0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  we_q      <= req_we;
                  addr_q    <= req_addr;
                  err_q     <= req_misaligned;
                  req_ready <= 1'b0;
                  if (store_io) begin
                     io_out <= req_wdata;
                  end
                  if (LATENCY == 0) begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rsp_rdata_next;
                     rsp_err   <= req_misaligned;
                  end else begin
                     wait_cnt <= 4'(LATENCY - 1);
                     state    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rsp_rdata_next;
                  rsp_err   <= err_q;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_RESP: begin
               // req_ready stays low on the handshake edge, so a waiting
               // request is taken no earlier than one edge after this.
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with LATENCY=2 (unit 0) and one
// with LATENCY=0 (unit 1), directed steps followed by random traffic checked
// against a word-array reference model and an expected-response queue.
module tb_data_mem_responder;

   localparam logic [9:0] IO_A = 10'h3FC;
   localparam int LAT [2] = '{2, 0};

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   int   cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [9:0]  req_addr  [2];
   logic [31:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic [31:0] io_out    [2];
   logic [1:0]  state_dbg [2];

   data_mem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(2), .IO_ADDR(10'h3FC)) dut_l2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .io_out(io_out[0]), .state_dbg(state_dbg[0])
   );

   data_mem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(0), .IO_ADDR(10'h3FC)) dut_l0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .io_out(io_out[1]), .state_dbg(state_dbg[1])
   );

   // ---------------- scoreboard / reference model ----------------
   int          checks;
   int          errors;
   logic [32:0] exp_q [$];          // {err, rdata} per accepted request
   logic [31:0] model_mem [2][256];
   logic [31:0] model_io [2];
   int          prev_acc [2];
   int          prev_hold [2];
   int          last_end [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference behaviour of one accepted request, from the rules directly.
   task automatic model_accept(input int u, input logic we, input logic [9:0] addr,
                               input logic [31:0] wdata);
      logic mis;
      mis = (addr % 4) != 0;
      if (mis) begin
         exp_q.push_back({1'b1, 32'h0});
      end else if (we) begin
         if (addr == IO_A) model_io[u] = wdata;
         else model_mem[u][addr / 4] = wdata;
         exp_q.push_back({1'b0, 32'h0});
      end else begin
         exp_q.push_back({1'b0, (addr == IO_A) ? model_io[u] : model_mem[u][addr / 4]});
      end
   endtask

   task automatic model_reset();
      model_io[0] = 32'h0;
      model_io[1] = 32'h0;
      exp_q.delete();
      last_end[0] = -1;
      last_end[1] = -1;
   endtask

   // ---------------- driver tasks ----------------
   // Present a request from IDLE and complete the accept edge.
   task automatic start_req(input int u, input logic we, input logic [9:0] addr,
                            input logic [31:0] wdata, input logic rdy);
      check("req_ready_idle", 32'(req_ready[u]), 32'd1);
      req_valid[u] = 1'b1;
      req_we[u]    = we;
      req_addr[u]  = addr;
      req_wdata[u] = wdata;
      rsp_ready[u] = rdy;
      @(posedge clk); #1;
      req_valid[u] = 1'b0;
      model_accept(u, we, addr, wdata);
      check("io_after_accept", io_out[u], model_io[u]);
   endtask

   // Full transaction; hold>0 keeps rsp_ready low that many cycles in RESP
   // while a junk store sits on the request channel.
   task automatic do_req(input int u, input logic we, input logic [9:0] addr,
                         input logic [31:0] wdata, input int hold);
      int k;
      int acc;
      logic [32:0] e;
      logic back_to_back;
      back_to_back = (cyc == last_end[u]);
      start_req(u, we, addr, wdata, hold == 0);
      acc = cyc;
      if (back_to_back)
         check("accept_spacing", 32'(acc - prev_acc[u]), 32'(LAT[u] + 2 + prev_hold[u]));
      k = 0;
      while (rsp_valid[u] !== 1'b1 && k < 40) begin
         check("req_ready_wait", 32'(req_ready[u]), 32'd0);
         @(posedge clk); #1;
         k++;
      end
      check("latency", 32'(k), 32'(LAT[u]));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
      check("rsp_rdata", rsp_rdata[u], e[31:0]);
      check("rsp_err", 32'(rsp_err[u]), 32'(e[32]));
      if (hold > 0) begin
         req_valid[u] = 1'b1;
         req_we[u]    = 1'b1;
         req_addr[u]  = addr & 10'h3FC;
         req_wdata[u] = 32'hBAD0BAD0;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", 32'(rsp_valid[u]), 32'd1);
            check("hold_rsp_rdata", rsp_rdata[u], e[31:0]);
            check("hold_rsp_err", 32'(rsp_err[u]), 32'(e[32]));
            check("hold_req_ready", 32'(req_ready[u]), 32'd0);
         end
         rsp_ready[u] = 1'b1;
      end
      @(posedge clk); #1;
      req_valid[u] = 1'b0;
      rsp_ready[u] = 1'b0;
      check("rsp_done_valid", 32'(rsp_valid[u]), 32'd0);
      check("rsp_done_ready", 32'(req_ready[u]), 32'd1);
      prev_acc[u]  = acc;
      prev_hold[u] = hold;
      last_end[u]  = cyc;
   endtask

   task automatic random_traffic(input int u, input int n);
      int sel;
      logic [9:0] addr;
      for (int w = 0; w < 16; w++) do_req(u, 1'b1, 10'(w * 4), $urandom, 0);
      for (int i = 0; i < n; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) addr = IO_A;
         else begin
            addr = 10'($urandom_range(0, 15) * 4);
            if (sel == 1) addr[1:0] = 2'($urandom_range(1, 3));
         end
         do_req(u, 1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3));
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      checks = 0;
      errors = 0;
      for (int u = 0; u < 2; u++) begin
         req_valid[u] = 1'b0;
         req_we[u]    = 1'b0;
         req_addr[u]  = 10'h0;
         req_wdata[u] = 32'h0;
         rsp_ready[u] = 1'b0;
         prev_acc[u]  = 0;
         prev_hold[u] = 0;
      end
      model_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      for (int u = 0; u < 2; u++) begin
         check("reset_req_ready", 32'(req_ready[u]), 32'd1);
         check("reset_rsp_valid", 32'(rsp_valid[u]), 32'd0);
         check("reset_rsp_rdata", rsp_rdata[u], 32'h0);
         check("reset_rsp_err", 32'(rsp_err[u]), 32'd0);
         check("reset_io_out", io_out[u], 32'h0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // store then load, LATENCY=2
      do_req(0, 1'b1, 10'h010, 32'hDEADBEEF, 0);
      do_req(0, 1'b0, 10'h010, 32'h0, 0);
      // memory-mapped output register
      do_req(0, 1'b1, IO_A, 32'h00000005, 0);
      do_req(0, 1'b0, IO_A, 32'h0, 0);
      do_req(0, 1'b0, 10'h010, 32'h0, 0);
      // misaligned accesses
      do_req(0, 1'b1, 10'h010, 32'h12345678, 0);
      do_req(0, 1'b0, 10'h013, 32'h0, 0);
      do_req(0, 1'b1, 10'h012, 32'hFFFFFFFF, 0);
      do_req(0, 1'b0, 10'h010, 32'h0, 0);
      // response back-pressure with a competing request
      do_req(0, 1'b0, 10'h010, 32'h0, 5);
      do_req(0, 1'b0, 10'h010, 32'h0, 0);
      // LATENCY=0 back-to-back
      do_req(1, 1'b1, 10'h020, 32'hCAFEF00D, 0);
      do_req(1, 1'b0, 10'h020, 32'h0, 0);
      do_req(1, 1'b0, 10'h020, 32'h0, 0);
      do_req(1, 1'b1, IO_A, 32'h00000077, 0);
      do_req(1, 1'b0, IO_A, 32'h0, 0);
      do_req(1, 1'b0, 10'h021, 32'h0, 2);

      // reset while waiting after an IO store
      start_req(0, 1'b1, IO_A, 32'hA5A5A5A5, 1'b1);
      check("io_store_a5", io_out[0], 32'hA5A5A5A5);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("rst_wait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("rst_wait_req_ready", 32'(req_ready[0]), 32'd1);
      check("rst_wait_io_out", io_out[0], 32'h0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      do_req(0, 1'b0, IO_A, 32'h0, 0);

      // reset while a store response is pending; the store stays committed
      start_req(0, 1'b1, 10'h020, 32'h11112222, 1'b0);
      repeat (LAT[0]) @(posedge clk);
      #1;
      check("pre_rst_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      rst = 1'b0;
      #1;
      model_reset();
      check("rst_resp_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("rst_resp_req_ready", 32'(req_ready[0]), 32'd1);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      do_req(0, 1'b0, 10'h020, 32'h0, 0);

      // random traffic on both latencies
      random_traffic(0, 60);
      random_traffic(1, 60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
